dual_digit_display_multiplexer: RTL and testbench
=================================================

DUAL_DIGIT_DISPLAY_MULTIPLEXER -- requirements
Module: dual_digit_display_multiplexer

Interface
REQ-001 Parameter REFRESH_CYCLES, default 24000, clock cycles each digit is lit per show phase (legal minimum 2).
REQ-002 Parameter BLANK_CYCLES, default 240, clock cycles of all-off dead time between show phases (legal minimum 1).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on rising clk edge.
REQ-005 most_recent_key  input  8  newest key from the upstream scanner/debouncer; [7:4] one-hot row, [3:0] one-hot column, 0 = none.
REQ-006 second_most_recent_key  input  8  previous key, same encoding.
REQ-007 segments  output  7  active-low segment drive; bit0=a through bit6=g.
REQ-008 anode_enable  output  2  active-low digit enables; bit1 = left digit, bit0 = right digit.

Function
REQ-009 Left digit SHALL show second_most_recent_key; right digit SHALL show most_recent_key.
REQ-010 Key decode by (row, column): r0: c0=E, c1=2, c2=3, c3=A; r1: c0=4, c1=5, c2=6, c3=B; r2: c0=7, c1=8, c2=9, c3=C; r3: c0=F, c1=1, c2=0, c3=D.
REQ-011 A code whose row nibble or column nibble is not exactly one-hot, including 8'h00, SHALL decode to blank (segments 7'h7F).
REQ-012 Active-high gfedcba patterns, inverted at the output: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71.
REQ-013 FSM states, in fixed cyclic order: BLANK_L -> SHOW_L -> BLANK_R -> SHOW_R -> BLANK_L.
REQ-014 A phase counter SHALL clear on every state change and increment otherwise.
REQ-015 Each BLANK state SHALL last exactly BLANK_CYCLES cycles; each SHOW state SHALL last exactly REFRESH_CYCLES cycles. A state exits on the edge where counter == duration-1.
REQ-016 The counter width SHALL be sized to the larger parameter; the counter SHALL never wrap inside a state.
REQ-017 In BLANK states: anode_enable = 2'b11 and segments = 7'h7F.
REQ-018 In SHOW_L: anode_enable = 2'b01. In SHOW_R: anode_enable = 2'b10.
REQ-019 On the edge entering SHOW_L or SHOW_R, the block SHALL snapshot the decode of the relevant key input at that edge and hold it for the whole phase.
REQ-020 Input changes during a SHOW phase SHALL NOT alter segments until the next entry into that digit's SHOW state.
REQ-021 All outputs SHALL be registered, with no combinational path from key inputs to outputs.
REQ-022 anode_enable SHALL never be 2'b00, in any cycle, including the cycles around reset.
REQ-023 Full refresh period SHALL be 2*(REFRESH_CYCLES+BLANK_CYCLES) cycles.

Reset
REQ-024 While reset is low at a clk edge: state = BLANK_L, counter = 0, segments = 7'h7F, anode_enable = 2'b11, snapshots cleared to blank.
REQ-025 Reset asserted mid-phase SHALL take effect at the next edge regardless of state or count; no partial phase completes.
REQ-026 After reset deasserts, SHOW_L SHALL be entered exactly BLANK_CYCLES edges later.

Verification (REFRESH_CYCLES=8, BLANK_CYCLES=2)
REQ-027 Case 1, reset then keys both 8'h00: anodes cycle 11(2) -> 01(8) -> 11(2) -> 10(8); segments stay 7'h7F throughout; period = 20 cycles.
REQ-028 Case 2, most_recent_key=8'b1000_0010 and second_most_recent_key=8'b0001_0010: SHOW_L segments = ~7'h5B = 7'h24 (digit 2); SHOW_R segments = ~7'h06 = 7'h79 (digit 1).
REQ-029 Case 3, most_recent_key changes from 8'b0001_1000 (A) to 8'b1000_1000 (D) at cycle 3 of SHOW_R: segments hold 7'h08 for the rest of that phase; the next SHOW_R shows 7'h21.
REQ-030 Case 4, invalid code 8'b0011_0001 on the right and 8'b0100_0001 (7) on the left: right digit blank (7'h7F); left digit 7'h78.
REQ-031 Case 5, reset pulled low at cycle 5 of SHOW_L: the next edge gives anode_enable = 2'b11 and segments = 7'h7F; after release, SHOW_L begins 2 edges later.
REQ-032 Every case: a continuous assertion checks that anode_enable != 2'b00, and that segments == 7'h7F whenever anode_enable == 2'b11.

Source files
------------

// File: rtl/dual_digit_display_multiplexer.sv
// ---------------------------------------------------------------------------
// dual_digit_display_multiplexer
//
// Time-multiplexes two 7-segment digits that share one segment bus. The left
// digit shows the previous key and the right digit shows the newest key. Each
// digit is lit for REFRESH_CYCLES clocks. Between show phases there are
// BLANK_CYCLES clocks of all-off dead time, which avoids ghosting while the
// anode drivers switch. The fixed cycle is:
//   BLANK_L -> SHOW_L -> BLANK_R -> SHOW_R -> BLANK_L ...
//
// A key code is {row[3:0], col[3:0]}, where each nibble is one-hot. Any code
// whose nibbles are not both one-hot decodes to a blank digit.
//
// Parameters
//   REFRESH_CYCLES  clocks each digit is lit per show phase (>= 2)
//   BLANK_CYCLES    clocks of dead time between show phases (>= 1)
//
// Ports
//   clk                     system clock, rising-edge active
//   reset                   synchronous, active-low reset
//   most_recent_key         newest key code, shown on the right digit
//   second_most_recent_key  previous key code, shown on the left digit
//   segments                active-low segment drive, bit0 = a .. bit6 = g
//   anode_enable            active-low digit enables, bit1 = left, bit0 = right
// ---------------------------------------------------------------------------
module dual_digit_display_multiplexer #(
    parameter int unsigned REFRESH_CYCLES = 24000,
    parameter int unsigned BLANK_CYCLES   = 240
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] most_recent_key,
    input  logic [7:0] second_most_recent_key,
    output logic [6:0] segments,
    output logic [1:0] anode_enable
);

    // The counter is sized to hold the longer phase's final count.
    localparam int unsigned MaxCycles = (REFRESH_CYCLES > BLANK_CYCLES) ?
                                        REFRESH_CYCLES : BLANK_CYCLES;
    localparam int unsigned CntWidth  = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    localparam logic [CntWidth-1:0] RefreshLast = CntWidth'(REFRESH_CYCLES - 1);
    localparam logic [CntWidth-1:0] BlankLast   = CntWidth'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        StBlankL,
        StShowL,
        StBlankR,
        StShowR
    } state_e;

    // -----------------------------------------------------------------------
    // Decode helpers
    // -----------------------------------------------------------------------

    // Returns {valid, hex}. Only the 16 codes with both nibbles one-hot are
    // valid, so the case items also reject every malformed code.
    function automatic logic [4:0] key_to_hex(input logic [7:0] key);
        logic [4:0] result;
        result = 5'h00;
        case (key)
            8'h11:   result = {1'b1, 4'hE};
            8'h12:   result = {1'b1, 4'h2};
            8'h14:   result = {1'b1, 4'h3};
            8'h18:   result = {1'b1, 4'hA};
            8'h21:   result = {1'b1, 4'h4};
            8'h22:   result = {1'b1, 4'h5};
            8'h24:   result = {1'b1, 4'h6};
            8'h28:   result = {1'b1, 4'hB};
            8'h41:   result = {1'b1, 4'h7};
            8'h42:   result = {1'b1, 4'h8};
            8'h44:   result = {1'b1, 4'h9};
            8'h48:   result = {1'b1, 4'hC};
            8'h81:   result = {1'b1, 4'hF};
            8'h82:   result = {1'b1, 4'h1};
            8'h84:   result = {1'b1, 4'h0};
            8'h88:   result = {1'b1, 4'hD};
            default: result = 5'h00;
        endcase
        return result;
    endfunction

    // Active-high gfedcba pattern for a hex digit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        seg = 7'h00;
        case (hex)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    // Active-high lit pattern for a key code; all zeros means blank.
    function automatic logic [6:0] key_to_lit(input logic [7:0] key);
        logic [4:0] vh;
        vh = key_to_hex(key);
        return vh[4] ? hex_to_seg(vh[3:0]) : 7'h00;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------

    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;

    // Snapshots and output registers are held active-high, so that the
    // all-zero value means "dark". The output pins are their inversion.
    // Because of this, a register that has never been written also reads as
    // anodes off and segments off, rather than as both digits enabled.
    logic [6:0] snap_l_q, snap_l_d;
    logic [6:0] snap_r_q, snap_r_d;
    logic [6:0] seg_on_q, seg_on_d;
    logic [1:0] anode_on_q, anode_on_d;

    logic       phase_done;
    logic [6:0] lit_left;
    logic [6:0] lit_right;

    assign lit_left  = key_to_lit(second_most_recent_key);
    assign lit_right = key_to_lit(most_recent_key);

    // -----------------------------------------------------------------------
    // Process 1: state, counter, snapshot and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StBlankL;
            cnt_q      <= '0;
            snap_l_q   <= 7'h00;
            snap_r_q   <= 7'h00;
            seg_on_q   <= 7'h00;
            anode_on_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            snap_l_q   <= snap_l_d;
            snap_r_q   <= snap_r_d;
            seg_on_q   <= seg_on_d;
            anode_on_q <= anode_on_d;
        end
    end

    // -----------------------------------------------------------------------
    // Process 2: next state, phase counter and snapshots
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CntWidth'(1);
        snap_l_d = snap_l_q;
        snap_r_d = snap_r_q;

        unique case (state_q)
            StShowL, StShowR: phase_done = (cnt_q == RefreshLast);
            default:          phase_done = (cnt_q == BlankLast);
        endcase

        if (phase_done) begin
            cnt_d = '0;
            unique case (state_q)
                StBlankL: begin
                    state_d  = StShowL;
                    // Capture the key on the entry edge and hold it for the
                    // whole show phase.
                    snap_l_d = lit_left;
                end
                StShowL:  state_d = StBlankR;
                StBlankR: begin
                    state_d  = StShowR;
                    snap_r_d = lit_right;
                end
                default:  state_d = StBlankL;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Process 3: outputs
    // The next output values are decoded from the next state. Registering
    // them keeps the pins in step with state_q, and no key input reaches a
    // pin without passing through a flop.
    // -----------------------------------------------------------------------
    always_comb begin
        seg_on_d   = 7'h00;
        anode_on_d = 2'b00;
        unique case (state_d)
            StShowL: begin
                anode_on_d = 2'b10;
                seg_on_d   = snap_l_d;
            end
            StShowR: begin
                anode_on_d = 2'b01;
                seg_on_d   = snap_r_d;
            end
            default: begin
                anode_on_d = 2'b00;
                seg_on_d   = 7'h00;
            end
        endcase
    end

    assign segments     = ~seg_on_q;
    assign anode_enable = ~anode_on_q;

endmodule

// File: tb/tb_dual_digit_display_multiplexer.sv
module tb_dual_digit_display_multiplexer;

    localparam int unsigned REFRESH = 8;
    localparam int unsigned BLANK   = 2;
    localparam int unsigned PERIOD  = 2 * (REFRESH + BLANK);

    logic       clk;
    logic       reset;
    logic [7:0] most_recent_key;
    logic [7:0] second_most_recent_key;
    logic [6:0] segments;
    logic [1:0] anode_enable;

    int tests;
    int fails;
    int pos;
    bit mon_en;

    dual_digit_display_multiplexer #(
        .REFRESH_CYCLES(REFRESH),
        .BLANK_CYCLES  (BLANK)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .most_recent_key       (most_recent_key),
        .second_most_recent_key(second_most_recent_key),
        .segments              (segments),
        .anode_enable          (anode_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed {an,seg}=%h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge while running. pos is the cycle position within the
    // refresh period: 0-1 BLANK_L, 2-9 SHOW_L, 10-11 BLANK_R, 12-19 SHOW_R.
    task automatic tick(input string cname, input logic [6:0] seg_l, input logic [6:0] seg_r);
        logic [8:0] exp;
        @(posedge clk);
        #1;
        pos = (pos + 1) % PERIOD;
        if (pos >= 2 && pos <= 9)        exp = {2'b01, seg_l};
        else if (pos >= 12 && pos <= 19) exp = {2'b10, seg_r};
        else                             exp = {2'b11, 7'h7F};
        chk($sformatf("%s p=%0d", cname, pos), {anode_enable, segments}, exp);
    endtask

    task automatic reset_tick(input string cname);
        @(posedge clk);
        #1;
        pos = 0;
        chk(cname, {anode_enable, segments}, {2'b11, 7'h7F});
    endtask

    // Always-on checks, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            tests++;
            assert (anode_enable !== 2'b00)
            else begin
                fails++;
                $error("FAIL anode_both_on: observed %b expected not 00", anode_enable);
            end
            if (anode_enable === 2'b11) begin
                tests++;
                assert (segments === 7'h7F)
                else begin
                    fails++;
                    $error("FAIL blank_segments: observed %h expected 7f", segments);
                end
            end
        end
    end

    initial begin
        tests  = 0;
        fails  = 0;
        pos    = 0;
        mon_en = 1'b0;
        reset  = 1'b0;
        most_recent_key        = 8'h00;
        second_most_recent_key = 8'h00;

        // Case 1: reset state, then both keys idle for two full periods.
        reset_tick("reset_0");
        mon_en = 1'b1;
        reset_tick("reset_1");
        reset = 1'b1;
        for (int i = 0; i < 2 * PERIOD; i++) tick("c1_idle", 7'h7F, 7'h7F);

        // Case 2: left shows 2 and right shows 1.
        most_recent_key        = 8'b1000_0010;
        second_most_recent_key = 8'b0001_0010;
        for (int i = 0; i < PERIOD; i++) tick("c2_digits", 7'h24, 7'h79);

        // Case 3: the right key changes from A to D partway through SHOW_R.
        most_recent_key = 8'b0001_1000;
        for (int i = 0; i < 15; i++) tick("c3_a", 7'h24, 7'h08);
        most_recent_key = 8'b1000_1000;
        for (int i = 0; i < 5; i++) tick("c3_hold", 7'h24, 7'h08);
        for (int i = 0; i < PERIOD; i++) tick("c3_d", 7'h24, 7'h21);

        // Case 4: an invalid code on the right and 7 on the left.
        most_recent_key        = 8'b0011_0001;
        second_most_recent_key = 8'b0100_0001;
        for (int i = 0; i < PERIOD; i++) tick("c4_invalid", 7'h78, 7'h7F);

        // Case 5: reset is asserted at SHOW_L cycle 5 (pos 7).
        for (int i = 0; i < 7; i++) tick("c5_pre", 7'h78, 7'h7F);
        reset = 1'b0;
        reset_tick("c5_reset_0");
        reset_tick("c5_reset_1");
        reset = 1'b1;
        for (int i = 0; i < PERIOD; i++) tick("c5_post", 7'h78, 7'h7F);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
